// File: rtl/vector_instr_issuer_if.sv
// vector_instr_issuer_if: groups the host push port and the processor issue
// port of vector_instr_issuer. The issuer connects through the slave modport;
// the host/bench side uses master.
interface vector_instr_issuer_if #(
  parameter int ADDR_W = 9
);
  // Host side: packed word {opcode[1:0], mem_addr[ADDR_W-1:0], reg_select[1:0]}
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W+3:0] in_word;

  // Processor side
  logic              vp_valid;
  logic [1:0]        vp_instruction;
  logic [ADDR_W-1:0] vp_mem_addr;
  logic [1:0]        vp_reg_select;

  // Status
  logic              oob_err;
  logic [7:0]        oob_count;
  logic              idle;

  modport slave (
    input  in_valid, in_word,
    output in_ready, vp_valid, vp_instruction, vp_mem_addr, vp_reg_select,
           oob_err, oob_count, idle
  );

  modport master (
    output in_valid, in_word,
    input  in_ready, vp_valid, vp_instruction, vp_mem_addr, vp_reg_select,
           oob_err, oob_count, idle
  );
endinterface

// File: rtl/vector_instr_issuer.sv
// vector_instr_issuer: front-end sequencer for the vector processor.
// Buffers host instruction words in a small FIFO, issues at most one per
// cycle, drops load/store words whose vector access would run past the end
// of memory, and inserts a single stall cycle when a store of A3/A4 follows
// an add/mul directly.
// Optional macro VPI_PERF_CNT_EN adds the perf_issued/perf_stalls counters.
module vector_instr_issuer #(
  parameter int DEPTH     = 4,    // FIFO entries, power of two, >= 2
  parameter int ADDR_W    = 9,    // memory word-address width
  parameter int MEM_WORDS = 512,  // memory size in 32-bit words
  parameter int VEC_LEN   = 16    // words touched by one vector access
) (
  input  logic clk,
  input  logic rst,
`ifdef VPI_PERF_CNT_EN
  output logic [15:0] perf_issued,
  output logic [15:0] perf_stalls,
`endif
  vector_instr_issuer_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WORD_W = ADDR_W + 4;

  // Bound check operands, widened by one bit so the sum cannot overflow.
  localparam logic [ADDR_W:0] VEC_LEN_X   = (ADDR_W+1)'(VEC_LEN);
  localparam logic [ADDR_W:0] MEM_WORDS_X = (ADDR_W+1)'(MEM_WORDS);

  localparam logic [1:0] OP_STORE = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_STALL = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers (extra MSB on each pointer marks wrap parity)
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    occupancy;
  logic              fifo_empty;
  logic              fifo_full;
  logic              one_left;
  logic              push;
  logic              pop;

  // Head-of-queue decode
  logic [WORD_W-1:0] head_word;
  logic [1:0]        head_op;
  logic [ADDR_W-1:0] head_addr;
  logic [1:0]        head_reg;
  logic [ADDR_W:0]   head_end;
  logic              head_is_mem;
  logic              head_oob;
  logic              hazard;
  logic              drop;
  logic              issue;

  // Control state
  state_t            state_q, state_d;

  // Registered outputs
  logic              vp_valid_q, vp_valid_d;
  logic [1:0]        vp_instr_q, vp_instr_d;
  logic [ADDR_W-1:0] vp_addr_q, vp_addr_d;
  logic [1:0]        vp_reg_q, vp_reg_d;
  logic              oob_err_q, oob_err_d;
  logic [7:0]        oob_count_q, oob_count_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign occupancy  = wr_ptr_q - rd_ptr_q;
  assign one_left   = (occupancy == {{PTR_W{1'b0}}, 1'b1});

  // A full FIFO refuses the word even if a pop happens in the same cycle.
  assign push     = bus.in_valid && !fifo_full;
  assign wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};

  assign head_word   = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign head_op     = head_word[WORD_W-1 -: 2];
  assign head_addr   = head_word[ADDR_W+1:2];
  assign head_reg    = head_word[1:0];
  assign head_is_mem = (head_op[1] == 1'b0);        // load or store
  assign head_end    = {1'b0, head_addr} + VEC_LEN_X;
  assign head_oob    = (head_end > MEM_WORDS_X);

  // The processor needs one extra cycle before an A3/A4 store can follow an
  // add/mul. Only a genuinely issued add/mul (vp_valid high) arms this, so a
  // dropped word never creates a hazard.
  assign hazard = !fifo_empty && vp_valid_q && vp_instr_q[1] &&
                  (head_op == OP_STORE) && head_reg[1];

  // FIFO write port; storage needs no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.in_word;
    end
  end

  // Next-state and pop decision. A word is popped from IDLE or STALL as soon
  // as one is present so the first word issues one edge after its push.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE, S_STALL: begin
        if (fifo_empty) begin
          state_d = S_IDLE;
        end else begin
          pop     = 1'b1;
          state_d = (one_left && !push) ? S_IDLE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fifo_empty) begin
          state_d = S_IDLE;
        end else if (hazard) begin
          state_d = S_STALL;
        end else begin
          pop     = 1'b1;
          state_d = (one_left && !push) ? S_IDLE : S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Issue/drop datapath: a popped word either drives the processor or is
  // discarded with an error pulse; outputs hold their last value otherwise.
  always_comb begin
    drop        = pop && head_is_mem && head_oob;
    issue       = pop && !drop;
    vp_valid_d  = issue;
    vp_instr_d  = vp_instr_q;
    vp_addr_d   = vp_addr_q;
    vp_reg_d    = vp_reg_q;
    oob_err_d   = drop;
    oob_count_d = oob_count_q;
    if (issue) begin
      vp_instr_d = head_op;
      vp_addr_d  = head_addr;
      vp_reg_d   = head_reg;
    end
    if (drop && (oob_count_q != 8'hFF)) begin
      oob_count_d = oob_count_q + 8'd1;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      vp_valid_q  <= 1'b0;
      vp_instr_q  <= 2'b00;
      vp_addr_q   <= '0;
      vp_reg_q    <= 2'b00;
      oob_err_q   <= 1'b0;
      oob_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      vp_valid_q  <= vp_valid_d;
      vp_instr_q  <= vp_instr_d;
      vp_addr_q   <= vp_addr_d;
      vp_reg_q    <= vp_reg_d;
      oob_err_q   <= oob_err_d;
      oob_count_q <= oob_count_d;
    end
  end

`ifdef VPI_PERF_CNT_EN
  logic [15:0] perf_issued_q;
  logic [15:0] perf_stalls_q;

  // Wrapping counts of issue strobes and of cycles spent in STALL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q <= 16'd0;
      perf_stalls_q <= 16'd0;
    end else begin
      if (vp_valid_d) perf_issued_q <= perf_issued_q + 16'd1;
      if (state_d == S_STALL) perf_stalls_q <= perf_stalls_q + 16'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stalls = perf_stalls_q;
`endif

  assign bus.in_ready       = !fifo_full;
  assign bus.vp_valid       = vp_valid_q;
  assign bus.vp_instruction = vp_instr_q;
  assign bus.vp_mem_addr    = vp_addr_q;
  assign bus.vp_reg_select  = vp_reg_q;
  assign bus.oob_err        = oob_err_q;
  assign bus.oob_count      = oob_count_q;
  assign bus.idle           = fifo_empty && (state_q == S_IDLE) && !vp_valid_q;

endmodule

// File: tb/tb_vector_instr_issuer.sv
// tb_vector_instr_issuer: directed bench for vector_instr_issuer. A negedge
// monitor records every issued word with its edge number; each test task
// drives its scenario and compares against hand-computed values.
module tb_vector_instr_issuer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  vector_instr_issuer_if #(.ADDR_W(9)) bus ();

`ifdef VPI_PERF_CNT_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_stalls;
`endif

  vector_instr_issuer #(
    .DEPTH(DEPTH), .ADDR_W(9), .MEM_WORDS(512), .VEC_LEN(16)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef VPI_PERF_CNT_EN
    .perf_issued(perf_issued),
    .perf_stalls(perf_stalls),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [12:0] iss_q[$];
  int          iss_cyc[$];
  int          oob_pulses = 0;
  bit          ready_low_seen = 0;

  // Record each issue strobe and each drop pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.vp_valid) begin
        iss_q.push_back({bus.vp_instruction, bus.vp_mem_addr, bus.vp_reg_select});
        iss_cyc.push_back(cyc);
      end
      if (bus.oob_err) oob_pulses++;
    end
  end

  function automatic logic [12:0] mk(input logic [1:0] op, input int addr, input logic [1:0] r);
    logic [31:0] a;
    a = addr;
    return {op, a[8:0], r};
  endfunction

  task automatic clear_log();
    iss_q.delete();
    iss_cyc.delete();
    oob_pulses = 0;
    ready_low_seen = 0;
  endtask

  // Presents w and holds it until accepted; returns the edge of acceptance.
  task automatic drive_word(input logic [12:0] w, output int push_cyc);
    int waited;
    waited = 0;
    push_cyc = -1;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    while (!bus.in_ready && waited < 64) begin
      ready_low_seen = 1;
      @(posedge clk); #1;
      waited++;
    end
    if (bus.in_ready) begin
      @(posedge clk); #1;
      push_cyc = cyc;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.idle) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_log();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_word  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
    n_cmp++; if (bus.vp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_vp_valid: got %b want 0", bus.vp_valid); end
    n_cmp++; if ({bus.vp_instruction, bus.vp_mem_addr, bus.vp_reg_select} !== 13'h0) begin n_bad++;
      $display("FAIL reset_vp_bus: got %h want 0", {bus.vp_instruction, bus.vp_mem_addr, bus.vp_reg_select}); end
    n_cmp++; if ({bus.oob_err, bus.oob_count} !== 9'h0) begin n_bad++;
      $display("FAIL reset_oob: got %h want 0", {bus.oob_err, bus.oob_count}); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL reset_release_idle: got %b want 1", bus.idle); end
    $display("test_reset done");
  endtask

  task automatic test_single_load();
    int pc;
    bit ok;
    clear_log();
    drive_word(13'h0001, pc);
    bus.in_valid = 1'b0;
    wait_idle(20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_idle_timeout: got busy want idle"); end
    n_cmp++; if (iss_q.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", iss_q.size()); end
    if (iss_q.size() >= 1) begin
      n_cmp++; if (iss_q[0] !== 13'h0001) begin n_bad++; $display("FAIL single_word: got %h want 0001", iss_q[0]); end
      n_cmp++; if (iss_cyc[0] !== pc + 1) begin n_bad++; $display("FAIL single_latency: got edge %0d want %0d", iss_cyc[0], pc + 1); end
    end
    n_cmp++; if (oob_pulses !== 0) begin n_bad++; $display("FAIL single_oob: got %0d want 0", oob_pulses); end
    $display("test_single_load: pushed edge %0d, issued %0d", pc, iss_q.size());
  endtask

  task automatic test_oob();
    int pc;
    bit ok;
    logic [12:0] exp0, exp1;
    clear_log();
    exp0 = mk(2'b01, 496, 2'd0);
    exp1 = mk(2'b10, 511, 2'd1);
    drive_word(mk(2'b01, 497, 2'd0), pc);
    drive_word(exp0, pc);
    drive_word(exp1, pc);
    bus.in_valid = 1'b0;
    wait_idle(20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL oob_idle_timeout: got busy want idle"); end
    n_cmp++; if (oob_pulses !== 1) begin n_bad++; $display("FAIL oob_pulses: got %0d want 1", oob_pulses); end
    n_cmp++; if (bus.oob_count !== 8'd1) begin n_bad++; $display("FAIL oob_count: got %0d want 1", bus.oob_count); end
    n_cmp++; if (iss_q.size() !== 2) begin n_bad++; $display("FAIL oob_issue_count: got %0d want 2", iss_q.size()); end
    if (iss_q.size() == 2) begin
      n_cmp++; if (iss_q[0] !== exp0) begin n_bad++; $display("FAIL oob_store496: got %h want %h", iss_q[0], exp0); end
      n_cmp++; if (iss_q[1] !== exp1) begin n_bad++; $display("FAIL oob_add511: got %h want %h", iss_q[1], exp1); end
    end
    $display("test_oob: drops %0d, issued %0d", oob_pulses, iss_q.size());
  endtask

  task automatic test_hazard();
    logic [12:0] first_w [5];
    logic [12:0] second_w[5];
    int          gap_w   [5];
    int pc;
    bit ok;
    first_w[0] = mk(2'b10, 0, 2'd0);  second_w[0] = mk(2'b01, 10, 2'd2); gap_w[0] = 2;
    first_w[1] = mk(2'b10, 0, 2'd0);  second_w[1] = mk(2'b01, 10, 2'd0); gap_w[1] = 1;
    first_w[2] = mk(2'b11, 0, 2'd1);  second_w[2] = mk(2'b00, 20, 2'd3); gap_w[2] = 1;
    first_w[3] = mk(2'b11, 0, 2'd1);  second_w[3] = mk(2'b01, 30, 2'd3); gap_w[3] = 2;
    first_w[4] = mk(2'b10, 0, 2'd2);  second_w[4] = mk(2'b11, 40, 2'd3); gap_w[4] = 1;
    for (int k = 0; k < 5; k++) begin
      clear_log();
      drive_word(first_w[k], pc);
      drive_word(second_w[k], pc);
      bus.in_valid = 1'b0;
      wait_idle(20, ok);
      n_cmp++; if (iss_q.size() !== 2) begin n_bad++; $display("FAIL hazard_count[%0d]: got %0d want 2", k, iss_q.size()); end
      if (iss_q.size() == 2) begin
        n_cmp++; if (iss_cyc[1] - iss_cyc[0] !== gap_w[k]) begin n_bad++;
          $display("FAIL hazard_spacing[%0d]: got %0d want %0d", k, iss_cyc[1] - iss_cyc[0], gap_w[k]); end
        n_cmp++; if (iss_q[1] !== second_w[k]) begin n_bad++;
          $display("FAIL hazard_word[%0d]: got %h want %h", k, iss_q[1], second_w[k]); end
      end
      $display("test_hazard[%0d]: spacing %0d", k, (iss_q.size() == 2) ? iss_cyc[1] - iss_cyc[0] : -1);
    end
  endtask

  task automatic test_stream();
    logic [12:0] exp[DEPTH+2];
    int pc;
    bit ok;
    clear_log();
    for (int i = 0; i < DEPTH + 2; i++) exp[i] = mk(2'b00, 16 * i, 2'(i));
    for (int i = 0; i < DEPTH + 2; i++) drive_word(exp[i], pc);
    bus.in_valid = 1'b0;
    wait_idle(30, ok);
    n_cmp++; if (ready_low_seen !== 0) begin n_bad++; $display("FAIL stream_ready: got dropped want always 1"); end
    n_cmp++; if (iss_q.size() !== DEPTH + 2) begin n_bad++; $display("FAIL stream_count: got %0d want %0d", iss_q.size(), DEPTH + 2); end
    if (iss_q.size() == DEPTH + 2) begin
      for (int i = 0; i < DEPTH + 2; i++) begin
        n_cmp++; if (iss_q[i] !== exp[i]) begin n_bad++; $display("FAIL stream_order[%0d]: got %h want %h", i, iss_q[i], exp[i]); end
      end
      n_cmp++; if (iss_cyc[DEPTH+1] - iss_cyc[0] !== DEPTH + 1) begin n_bad++;
        $display("FAIL stream_rate: got %0d want %0d", iss_cyc[DEPTH+1] - iss_cyc[0], DEPTH + 1); end
    end
    $display("test_stream: issued %0d", iss_q.size());
  endtask

  // add/store-A3 pairs stall every third cycle, so continuous pushes fill the FIFO.
  task automatic test_full();
    logic [12:0] exp[24];
    int pc;
    bit ok;
    clear_log();
    for (int i = 0; i < 12; i++) begin
      exp[2*i]   = mk(2'b10, i, 2'd0);
      exp[2*i+1] = mk(2'b01, i, 2'd2);
    end
    for (int i = 0; i < 24; i++) drive_word(exp[i], pc);
    bus.in_valid = 1'b0;
    wait_idle(200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_idle_timeout: got busy want idle"); end
    n_cmp++; if (ready_low_seen !== 1) begin n_bad++; $display("FAIL full_ready_low: got never low want low at full"); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_after: got %b want 1", bus.in_ready); end
    n_cmp++; if (iss_q.size() !== 24) begin n_bad++; $display("FAIL full_count: got %0d want 24", iss_q.size()); end
    if (iss_q.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        n_cmp++; if (iss_q[i] !== exp[i]) begin n_bad++; $display("FAIL full_order[%0d]: got %h want %h", i, iss_q[i], exp[i]); end
      end
    end
    $display("test_full: issued %0d, backpressure %0d", iss_q.size(), ready_low_seen);
  endtask

  task automatic test_reset_mid();
    int pc;
    clear_log();
    for (int i = 0; i < 9; i++) drive_word((i % 2 == 0) ? mk(2'b10, i, 2'd0) : mk(2'b01, i, 2'd3), pc);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.vp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_vp_valid: got %b want 0", bus.vp_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle: got %b want 1", bus.idle); end
    n_cmp++; if (bus.oob_count !== 8'd0) begin n_bad++; $display("FAIL rstmid_oob_count: got %0d want 0", bus.oob_count); end
    n_cmp++; if ({bus.vp_instruction, bus.vp_mem_addr, bus.vp_reg_select} !== 13'h0) begin n_bad++;
      $display("FAIL rstmid_vp_bus: got %h want 0", {bus.vp_instruction, bus.vp_mem_addr, bus.vp_reg_select}); end
    @(posedge clk); #3;
    rst = 1'b0;
    clear_log();
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (iss_q.size() !== 0) begin n_bad++; $display("FAIL rstmid_no_issue: got %0d want 0", iss_q.size()); end
    n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle_after: got %b want 1", bus.idle); end
    $display("test_reset_mid: issued after release %0d", iss_q.size());
  endtask

  task automatic test_saturate();
    int pc;
    bit ok;
    clear_log();
    for (int i = 0; i < 300; i++) drive_word(mk(2'b00, 497 + (i % 15), 2'(i)), pc);
    bus.in_valid = 1'b0;
    wait_idle(50, ok);
    n_cmp++; if (bus.oob_count !== 8'd255) begin n_bad++; $display("FAIL sat_count: got %0d want 255", bus.oob_count); end
    n_cmp++; if (iss_q.size() !== 0) begin n_bad++; $display("FAIL sat_no_issue: got %0d want 0", iss_q.size()); end
    n_cmp++; if (oob_pulses !== 300) begin n_bad++; $display("FAIL sat_pulses: got %0d want 300", oob_pulses); end
    $display("test_saturate: oob_count %0d, pulses %0d", bus.oob_count, oob_pulses);
  endtask

`ifdef VPI_PERF_CNT_EN
  task automatic test_perf();
    logic [12:0] seq[10];
    int pc;
    bit ok;
    apply_reset();
    seq[0] = mk(2'b10, 0, 2'd0);
    seq[1] = mk(2'b01, 32, 2'd2);
    seq[2] = mk(2'b11, 0, 2'd1);
    seq[3] = mk(2'b01, 64, 2'd3);
    for (int i = 4; i < 10; i++) seq[i] = mk(2'b00, 16 * i, 2'(i));
    for (int i = 0; i < 10; i++) drive_word(seq[i], pc);
    bus.in_valid = 1'b0;
    wait_idle(50, ok);
    n_cmp++; if (perf_issued !== 16'd10) begin n_bad++; $display("FAIL perf_issued: got %0d want 10", perf_issued); end
    n_cmp++; if (perf_stalls !== 16'd2) begin n_bad++; $display("FAIL perf_stalls: got %0d want 2", perf_stalls); end
    n_cmp++; if (iss_q.size() !== 10) begin n_bad++; $display("FAIL perf_count: got %0d want 10", iss_q.size()); end
    $display("test_perf: issued %0d stalls %0d", perf_issued, perf_stalls);
  endtask
`endif

  initial begin
    test_reset();
    test_single_load();
    test_oob();
    test_hazard();
    test_stream();
    test_full();
    test_reset_mid();
    test_saturate();
`ifdef VPI_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vector_instr_issuer.md
Name: vector_instr_issuer

Overview:
- Front-end sequencer that drives the vector processor's instruction, mem_addr and reg_select inputs.
- Accepts packed instruction words from a host over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one instruction per cycle, with a one-cycle hazard stall and out-of-bound filtering ahead of the core.
- Sits between host/testbench and the vector processor; the processor has no enable, so integration gates it with vp_valid.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- ADDR_W, 9, memory word-address width.
- MEM_WORDS, 512, memory size in 32-bit words.
- VEC_LEN, 16, words per vector access; used for the bound check.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  host presents an instruction word.
- in_ready  output  1  FIFO can accept; high when not full.
- in_word  input  13  [12:11] opcode (00 load, 01 store, 10 add, 11 mul), [10:2] mem_addr, [1:0] reg_select.
- vp_valid  output  1  issue strobe; processor state may change only on cycles where it is 1.
- vp_instruction  output  2  opcode to the processor.
- vp_mem_addr  output  ADDR_W  address to the processor.
- vp_reg_select  output  2  register select to the processor.
- oob_err  output  1  one-cycle pulse when an instruction is dropped.
- oob_count  output  8  saturating count of dropped instructions.
- idle  output  1  FIFO empty, nothing issuing, state IDLE.

Behaviour:
- Reset: asynchronous, active-high. All outputs 0 except in_ready=1 and idle=1. FIFO pointers cleared; state IDLE.
- Reset mid-operation discards all FIFO contents and any pending stall.
- Push: occurs when in_valid && in_ready. When full, in_ready=0 and in_word is ignored.
- Simultaneous push and pop when full is not accepted, because in_ready is already 0.
- FIFO: pointers carry one extra wrap bit; full/empty are derived from pointer compare. First-word latency is 1 cycle: a word pushed at edge N can issue at edge N+1.
- Output registers: vp_* are registered. vp_valid is high for exactly one cycle per issued instruction.
- When vp_valid=0, vp_instruction, vp_mem_addr and vp_reg_select hold their last values.
- Bound check, load/store only: drop if mem_addr + VEC_LEN > MEM_WORDS, computed at ADDR_W+1 bits.
  - With the default parameters, addresses 497..511 are dropped.
  - Dropped word: popped, no vp_valid, oob_err pulses 1 cycle, oob_count += 1, saturating at 255.
- add and mul: the address is ignored and never dropped.
- State machine:
  - IDLE: FIFO empty. On non-empty, go to ISSUE.
  - ISSUE: pop the head each cycle and issue it or drop it. Go to STALL if the hazard rule fires; go to IDLE if the FIFO becomes empty.
  - STALL: exactly one cycle, vp_valid=0, no pop. Then return to ISSUE, or to IDLE if the FIFO is empty.
- Hazard rule: the cycle after issuing add or mul, if the head is a store with reg_select 2 or 3 (A3/A4), insert one STALL cycle.
  - A load to any register following add/mul is not stalled.
  - An add/mul following add/mul is not stalled.
- A dropped instruction counts as not issued, so it cannot create a hazard.
- idle = empty && state==IDLE && !vp_valid.

Optional Feature:
- Macro VPI_PERF_CNT_EN.
- Defined: adds output perf_issued [15:0], a wrapping count of vp_valid cycles, and output perf_stalls [15:0], a wrapping count of STALL cycles. Both clear on rst.
- Undefined: neither port exists and no counters are synthesised. All other behaviour is identical.

Test Plan:
- Reset then push load addr 0 reg 1 (word 0x0001) -> vp_valid one cycle after the push, vp_instruction=00, vp_mem_addr=0, vp_reg_select=1; oob_err stays 0.
- Push store addr 497 -> no vp_valid, oob_err pulses once, oob_count=1; a following store addr 496 issues normally.
- Push add then store reg 2 back-to-back -> add issues at cycle N, a one-cycle gap at N+1, store issues at N+2.
  - Repeat with store reg 0 -> no gap.
- With the sink never stalled, push DEPTH+2 words while holding in_valid -> in_ready stays 1 and all words issue in order.
  - Then freeze pops by holding the FIFO with rst-free back-pressure: preload 4 words in consecutive cycles during STALL -> in_ready drops to 0 at full, and the 5th word is held until space frees.
- Assert rst mid-stream with 3 words queued -> all outputs return to reset values immediately, nothing issues after release, and idle=1.
- Push 300 out-of-bound loads -> oob_count saturates at 255 and vp_valid never asserts.
  - With VPI_PERF_CNT_EN, a mixed stream of 10 issued instructions and 2 stalls -> perf_issued=10, perf_stalls=2.
